// File: rtl/rob_commit.sv
// Reorder-buffer retire stage: retires up to two in-order head entries per cycle,
// updates the ARAT and free list, and tracks head pointer, instret and ebreak halt.
module rob_commit #(
   parameter int ROB_DEPTH = 64,
   parameter int PC_W      = 64,
   parameter int LREG_W    = 5,
   parameter int PREG_W    = 6
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         h0_deq,
   input  logic                         h1_deq,
   input  logic [PC_W-1:0]              h0_pc,
   input  logic [PC_W-1:0]              h1_pc,
   input  logic [31:0]                  h0_instr,
   input  logic [31:0]                  h1_instr,
   input  logic [LREG_W-1:0]            h0_lrd,
   input  logic [LREG_W-1:0]            h1_lrd,
   input  logic [PREG_W-1:0]            h0_prd,
   input  logic [PREG_W-1:0]            h1_prd,
   input  logic [PREG_W-1:0]            h0_old_prd,
   input  logic [PREG_W-1:0]            h1_old_prd,
   input  logic                         h0_need_to_wb,
   input  logic                         h1_need_to_wb,
   input  logic                         h0_skip,
   input  logic                         h1_skip,
   output logic [$clog2(ROB_DEPTH):0]   head_ptr,
   output logic                         commit0,
   output logic                         commit1,
   output logic                         arat_wen0,
   output logic                         arat_wen1,
   output logic [LREG_W-1:0]            arat_waddr0,
   output logic [LREG_W-1:0]            arat_waddr1,
   output logic [PREG_W-1:0]            arat_wdata0,
   output logic [PREG_W-1:0]            arat_wdata1,
   output logic                         fl_rel_valid0,
   output logic                         fl_rel_valid1,
   output logic [PREG_W-1:0]            fl_rel_prd0,
   output logic [PREG_W-1:0]            fl_rel_prd1,
   input  logic                         fl_rel_ready,
   output logic [63:0]                  instret,
   output logic                         halted,
   output logic [1:0]                   dbg_valid,
   output logic [2*PC_W-1:0]            dbg_pc,
   output logic [63:0]                  dbg_instr,
   output logic [1:0]                   dbg_skip
);
   localparam int          PTR_W  = $clog2(ROB_DEPTH) + 1;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef enum logic {ST_RUN, ST_HALT} state_t;

   state_t             state_q;
   logic [PTR_W-1:0]   head_q, head_d;
   logic [63:0]        instret_q, instret_d;
   logic               halted_q;
   logic [1:0]         dbg_valid_q;
   logic [2*PC_W-1:0]  dbg_pc_q, dbg_pc_d;
   logic [63:0]        dbg_instr_q, dbg_instr_d;
   logic [1:0]         dbg_skip_q, dbg_skip_d;

   logic        wr0, wr1, ebrk0, ebrk1, run, halt_d;
   logic [1:0]  retire_cnt;
   logic [1:0]  commit_v;
   logic [1:0]  skip_v;
   logic [PC_W-1:0] pc_v [2];
   logic [31:0]     instr_v [2];

   assign wr0   = h0_need_to_wb & (h0_lrd != '0);
   assign wr1   = h1_need_to_wb & (h1_lrd != '0);
   assign ebrk0 = (h0_instr == EBREAK);
   assign ebrk1 = (h1_instr == EBREAK);
   // Reset masks retirement so pending head entries are not consumed during it.
   assign run   = (state_q == ST_RUN) & ~reset;

   assign commit0 = run & h0_deq & (~wr0 | fl_rel_ready);
   assign commit1 = commit0 & h1_deq & (~wr1 | fl_rel_ready) & ~ebrk0;

   assign arat_wen0     = commit0 & wr0;
   assign arat_wen1     = commit1 & wr1;
   assign arat_waddr0   = h0_lrd;
   assign arat_waddr1   = h1_lrd;
   assign arat_wdata0   = h0_prd;
   assign arat_wdata1   = h1_prd;
   assign fl_rel_valid0 = commit0 & wr0;
   assign fl_rel_valid1 = commit1 & wr1;
   assign fl_rel_prd0   = h0_old_prd;
   assign fl_rel_prd1   = h1_old_prd;

   assign retire_cnt = {1'b0, commit0} + {1'b0, commit1};
   // Power-of-two depth: natural overflow of the extra bit gives the wrap toggle.
   assign head_d     = head_q + PTR_W'(retire_cnt);
   assign instret_d  = instret_q + 64'(retire_cnt);
   assign halt_d     = (commit0 & ebrk0) | (commit1 & ebrk1);

   assign commit_v   = {commit1, commit0};
   assign skip_v     = {h1_skip, h0_skip};
   assign pc_v[0]    = h0_pc;
   assign pc_v[1]    = h1_pc;
   assign instr_v[0] = h0_instr;
   assign instr_v[1] = h1_instr;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dbg
      assign dbg_pc_d[gi*PC_W +: PC_W] = commit_v[gi] ? pc_v[gi] : '0;
      assign dbg_instr_d[gi*32 +: 32]  = commit_v[gi] ? instr_v[gi] : '0;
      assign dbg_skip_d[gi]            = commit_v[gi] & skip_v[gi];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_RUN;
         halted_q    <= 1'b0;
         head_q      <= '0;
         instret_q   <= '0;
         dbg_valid_q <= '0;
         dbg_pc_q    <= '0;
         dbg_instr_q <= '0;
         dbg_skip_q  <= '0;
      end else begin
         head_q      <= head_d;
         instret_q   <= instret_d;
         dbg_valid_q <= commit_v;
         dbg_pc_q    <= dbg_pc_d;
         dbg_instr_q <= dbg_instr_d;
         dbg_skip_q  <= dbg_skip_d;
         unique case (state_q)
            ST_RUN: begin
               if (halt_d) begin
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
               end
            end
            ST_HALT: begin
               state_q  <= ST_HALT;
               halted_q <= 1'b1;
            end
         endcase
      end
   end

   assign head_ptr  = head_q;
   assign instret   = instret_q;
   assign halted    = halted_q;
   assign dbg_valid = dbg_valid_q;
   assign dbg_pc    = dbg_pc_q;
   assign dbg_instr = dbg_instr_q;
   assign dbg_skip  = dbg_skip_q;
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: a per-cycle reference model of the retire rules
// plus hand-computed spot checks of the test-plan scenarios.
module tb_rob_commit;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset;
   logic        h0_deq, h1_deq;
   logic [63:0] h0_pc, h1_pc;
   logic [31:0] h0_instr, h1_instr;
   logic [4:0]  h0_lrd, h1_lrd;
   logic [5:0]  h0_prd, h1_prd, h0_old_prd, h1_old_prd;
   logic        h0_need_to_wb, h1_need_to_wb, h0_skip, h1_skip;
   logic [6:0]  head_ptr;
   logic        commit0, commit1, arat_wen0, arat_wen1;
   logic [4:0]  arat_waddr0, arat_waddr1;
   logic [5:0]  arat_wdata0, arat_wdata1;
   logic        fl_rel_valid0, fl_rel_valid1;
   logic [5:0]  fl_rel_prd0, fl_rel_prd1;
   logic        fl_rel_ready;
   logic [63:0] instret;
   logic        halted;
   logic [1:0]  dbg_valid;
   logic [127:0] dbg_pc;
   logic [63:0] dbg_instr;
   logic [1:0]  dbg_skip;

   rob_commit dut (
      .clock(clock), .reset(reset),
      .h0_deq(h0_deq), .h1_deq(h1_deq), .h0_pc(h0_pc), .h1_pc(h1_pc),
      .h0_instr(h0_instr), .h1_instr(h1_instr), .h0_lrd(h0_lrd), .h1_lrd(h1_lrd),
      .h0_prd(h0_prd), .h1_prd(h1_prd), .h0_old_prd(h0_old_prd), .h1_old_prd(h1_old_prd),
      .h0_need_to_wb(h0_need_to_wb), .h1_need_to_wb(h1_need_to_wb),
      .h0_skip(h0_skip), .h1_skip(h1_skip), .head_ptr(head_ptr),
      .commit0(commit0), .commit1(commit1), .arat_wen0(arat_wen0), .arat_wen1(arat_wen1),
      .arat_waddr0(arat_waddr0), .arat_waddr1(arat_waddr1),
      .arat_wdata0(arat_wdata0), .arat_wdata1(arat_wdata1),
      .fl_rel_valid0(fl_rel_valid0), .fl_rel_valid1(fl_rel_valid1),
      .fl_rel_prd0(fl_rel_prd0), .fl_rel_prd1(fl_rel_prd1), .fl_rel_ready(fl_rel_ready),
      .instret(instret), .halted(halted), .dbg_valid(dbg_valid), .dbg_pc(dbg_pc),
      .dbg_instr(dbg_instr), .dbg_skip(dbg_skip)
   );

   always #5 clock = ~clock;

   int cmp_cnt = 0;
   int err_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   int          m_head = 0;
   longint      m_instret = 0;
   bit          m_halted = 0;
   logic [1:0]  m_dv = '0;
   logic [63:0] m_dpc [2];
   logic [31:0] m_dins [2];
   logic        m_dskip [2];

   // How many of the two oldest entries may retire right now.
   function automatic int retire_count();
      int n = 0;
      if (reset || m_halted) return 0;
      for (int i = 0; i < 2; i++) begin
         logic dq, wr;
         logic [31:0] ins;
         dq  = (i == 0) ? h0_deq : h1_deq;
         wr  = (i == 0) ? (h0_need_to_wb && h0_lrd != 0) : (h1_need_to_wb && h1_lrd != 0);
         ins = (i == 0) ? h0_instr : h1_instr;
         if (!dq) return n;
         if (wr && !fl_rel_ready) return n;
         n++;
         if (ins == EBREAK) return n;
      end
      return n;
   endfunction

   always @(posedge clock) begin
      int n;
      n = retire_count();
      if (reset) begin
         m_head = 0; m_instret = 0; m_halted = 0; m_dv = '0;
      end else begin
         m_dv = {n >= 2, n >= 1};
         m_dpc[0] = h0_pc;  m_dins[0] = h0_instr; m_dskip[0] = h0_skip;
         m_dpc[1] = h1_pc;  m_dins[1] = h1_instr; m_dskip[1] = h1_skip;
         if (n >= 1 && h0_instr == EBREAK) m_halted = 1;
         if (n >= 2 && h1_instr == EBREAK) m_halted = 1;
         m_head = (m_head + n) % 128;
         m_instret = m_instret + n;
      end
   end

   always @(negedge clock) begin
      int n;
      bit e_w0, e_w1;
      n = retire_count();
      e_w0 = (n >= 1) && h0_need_to_wb && (h0_lrd != 0);
      e_w1 = (n >= 2) && h1_need_to_wb && (h1_lrd != 0);
      chk("m_commit0", 64'(commit0), 64'(n >= 1));
      chk("m_commit1", 64'(commit1), 64'(n >= 2));
      chk("m_arat_wen0", 64'(arat_wen0), 64'(e_w0));
      chk("m_arat_wen1", 64'(arat_wen1), 64'(e_w1));
      chk("m_fl_valid0", 64'(fl_rel_valid0), 64'(e_w0));
      chk("m_fl_valid1", 64'(fl_rel_valid1), 64'(e_w1));
      if (e_w0) begin
         chk("m_waddr0", 64'(arat_waddr0), 64'(h0_lrd));
         chk("m_wdata0", 64'(arat_wdata0), 64'(h0_prd));
         chk("m_fl_prd0", 64'(fl_rel_prd0), 64'(h0_old_prd));
      end
      if (e_w1) begin
         chk("m_waddr1", 64'(arat_waddr1), 64'(h1_lrd));
         chk("m_wdata1", 64'(arat_wdata1), 64'(h1_prd));
         chk("m_fl_prd1", 64'(fl_rel_prd1), 64'(h1_old_prd));
      end
      chk("m_head_ptr", 64'(head_ptr), 64'(m_head));
      chk("m_instret", instret, 64'(m_instret));
      chk("m_halted", 64'(halted), 64'(m_halted));
      chk("m_dbg_valid", 64'(dbg_valid), 64'(m_dv));
      if (m_dv[0]) begin
         chk("m_dbg_pc0", dbg_pc[63:0], m_dpc[0]);
         chk("m_dbg_instr0", 64'(dbg_instr[31:0]), 64'(m_dins[0]));
         chk("m_dbg_skip0", 64'(dbg_skip[0]), 64'(m_dskip[0]));
      end
      if (m_dv[1]) begin
         chk("m_dbg_pc1", dbg_pc[127:64], m_dpc[1]);
         chk("m_dbg_instr1", 64'(dbg_instr[63:32]), 64'(m_dins[1]));
         chk("m_dbg_skip1", 64'(dbg_skip[1]), 64'(m_dskip[1]));
      end
   end

   logic [63:0] pc_seq = 64'h8000_0000;

   task automatic slot(input int s, input logic dq, input logic [4:0] lrd,
                       input logic [5:0] prd, input logic [5:0] old, input logic nwb,
                       input logic [31:0] ins);
      pc_seq = pc_seq + 4;
      if (s == 0) begin
         h0_deq = dq; h0_lrd = lrd; h0_prd = prd; h0_old_prd = old;
         h0_need_to_wb = nwb; h0_instr = ins; h0_pc = pc_seq; h0_skip = lrd[0];
      end else begin
         h1_deq = dq; h1_lrd = lrd; h1_prd = prd; h1_old_prd = old;
         h1_need_to_wb = nwb; h1_instr = ins; h1_pc = pc_seq; h1_skip = lrd[0];
      end
   endtask

   task automatic idle();
      slot(0, 0, 0, 0, 0, 0, NOP);
      slot(1, 0, 0, 0, 0, 0, NOP);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1; fl_rel_ready = 1; idle();
      repeat (3) tick();
      chk("rst_head_ptr", 64'(head_ptr), 64'd0);
      chk("rst_instret", instret, 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_dbg_valid", 64'(dbg_valid), 64'd0);
      reset = 0;

      // Dual retire with two register writes
      slot(0, 1, 3, 10, 2, 1, NOP); slot(1, 1, 5, 11, 4, 1, NOP);
      #2;
      chk("t1_commit", 64'({commit1, commit0}), 64'b11);
      chk("t1_arat0", 64'({arat_waddr0, arat_wdata0}), 64'({5'd3, 6'd10}));
      chk("t1_arat1", 64'({arat_waddr1, arat_wdata1}), 64'({5'd5, 6'd11}));
      chk("t1_fl", 64'({fl_rel_valid1, fl_rel_valid0, fl_rel_prd1, fl_rel_prd0}),
          64'({1'b1, 1'b1, 6'd4, 6'd2}));
      tick();
      chk("t1_instret", instret, 64'd2);
      chk("t1_head_ptr", 64'(head_ptr), 64'd2);

      // Slot 1 alone never retires
      slot(0, 0, 0, 0, 0, 0, NOP); slot(1, 1, 6, 12, 1, 1, NOP);
      #2;
      chk("t2_commit", 64'({commit1, commit0}), 64'b00);
      tick();
      chk("t2_head_ptr", 64'(head_ptr), 64'd2);

      // Backpressure
      fl_rel_ready = 0;
      slot(0, 1, 8, 13, 3, 1, NOP); slot(1, 1, 9, 14, 5, 1, NOP);
      #2;
      chk("t3a_commit", 64'({commit1, commit0}), 64'b00);
      tick();
      slot(0, 1, 8, 13, 3, 0, NOP); slot(1, 1, 9, 14, 5, 1, NOP);
      #2;
      chk("t3b_commit", 64'({commit1, commit0}), 64'b01);
      chk("t3b_fl_valid0", 64'(fl_rel_valid0), 64'd0);
      tick();
      fl_rel_ready = 1;

      // Single retires up to index 63, mixing lrd=0 and need_to_wb=0
      for (int k = 0; k < 60; k++) begin
         slot(0, 1, (k % 3 == 0) ? 5'd0 : 5'(k), 6'(k), 6'(k + 1), k[0], NOP);
         slot(1, 0, 0, 0, 0, 0, NOP);
         tick();
      end
      chk("t4_head_pre", 64'(head_ptr), 64'd63);

      // +2 across the wrap
      slot(0, 1, 1, 30, 31, 1, NOP); slot(1, 1, 2, 32, 33, 1, NOP);
      tick();
      chk("t4_head_wrap", 64'(head_ptr), 64'd65);
      chk("t4_instret", instret, 64'd65);

      // Same lrd in both slots
      slot(0, 1, 7, 20, 9, 1, NOP); slot(1, 1, 7, 21, 20, 1, NOP);
      #2;
      chk("t6_wen", 64'({arat_wen1, arat_wen0}), 64'b11);
      chk("t6_arat", 64'({arat_waddr0, arat_wdata0, arat_waddr1, arat_wdata1}),
          64'({5'd7, 6'd20, 5'd7, 6'd21}));
      chk("t6_fl", 64'({fl_rel_prd0, fl_rel_prd1}), 64'({6'd9, 6'd20}));
      tick();

      // ebreak in slot 0 halts after itself
      slot(0, 1, 0, 0, 0, 0, EBREAK); slot(1, 1, 4, 15, 6, 1, NOP);
      #2;
      chk("t5_commit", 64'({commit1, commit0}), 64'b01);
      tick();
      chk("t5_halted", 64'(halted), 64'd1);
      slot(0, 1, 4, 15, 6, 1, NOP); slot(1, 1, 0, 0, 0, 0, NOP);
      #2;
      chk("t5_no_commit", 64'({commit1, commit0}), 64'b00);
      repeat (2) tick();

      // Reset mid-operation with pending entries
      reset = 1;
      #2;
      chk("rst2_commit", 64'(commit0), 64'd0);
      tick();
      chk("rst2_head_ptr", 64'(head_ptr), 64'd0);
      chk("rst2_halted", 64'(halted), 64'd0);
      reset = 0;

      // ebreak in slot 1 retires together with slot 0
      slot(0, 1, 2, 40, 41, 1, NOP); slot(1, 1, 0, 0, 0, 0, EBREAK);
      #2;
      chk("t7_commit", 64'({commit1, commit0}), 64'b11);
      tick();
      chk("t7_halted", 64'(halted), 64'd1);
      chk("t7_instret", instret, 64'd2);
      idle();
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
